// File: rtl/bennett_clock_seq_if.sv
// Handshake and clock-output bundle for bennett_clock_seq.
// Optional abort/aborted signals exist only when BENNETT_ABORT_EN is defined.
interface bennett_clock_seq_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SW    = $clog2(WIDTH + 1)
);
`ifdef BENNETT_ABORT_EN
  logic             abort;
  logic             aborted;
`endif
  logic             start;
  logic             auto_run;
  logic [SW-1:0]    n_stages;
  logic             Mclk;
  logic [WIDTH-1:0] clkp;
  logic [WIDTH-1:0] clkn;
  logic             instFlag;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;

  modport master (
`ifdef BENNETT_ABORT_EN
    output abort,
    input  aborted,
`endif
    output start, auto_run, n_stages,
    input  Mclk, clkp, clkn, instFlag, busy, done, stage
  );

  modport slave (
`ifdef BENNETT_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  start, auto_run, n_stages,
    output Mclk, clkp, clkn, instFlag, busy, done, stage
  );
endinterface

// File: rtl/bennett_clock_seq.sv
// Parametrised Bennett-clock sequencer: Mclk, ramped clkp/clkn stage pairs and instFlag peak.
// Define BENNETT_ABORT_EN to add the abort input and aborted pulse.
module bennett_clock_seq #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned HOLD        = 1,
  parameter int unsigned PEAK_CYCLES = 1,
  parameter int unsigned SW          = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                reset,
  bennett_clock_seq_if.slave bus
);
  localparam int unsigned TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned PW = (PEAK_CYCLES > 1) ? $clog2(PEAK_CYCLES) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(HOLD - 1);
  localparam logic [PW-1:0] PeakLast  = PW'(PEAK_CYCLES - 1);
  localparam logic [SW-1:0] FullN     = SW'(WIDTH);

  // StLaunch is the acceptance cycle: N is latched, Mclk rises on the following edge.
  typedef enum logic [2:0] {StIdle, StLaunch, StRaise, StPeak, StLower} state_e;

  state_e           state_q;
  logic [SW-1:0]    n_q;
  logic [SW-1:0]    stage_q;
  logic [TW-1:0]    timer_q;
  logic [PW-1:0]    peak_q;
  logic [WIDTH-1:0] clkp_q;
  logic [WIDTH-1:0] clkn_q;
  logic             mclk_q;
  logic             inst_q;
  logic             done_q;
`ifdef BENNETT_ABORT_EN
  logic             aborting_q;
  logic             aborted_q;
`endif

  logic          go;
  logic          timer_done;
  logic [SW-1:0] n_clamped;

  always_comb begin
    go         = bus.start | bus.auto_run;
    timer_done = (timer_q == TimerLast);
    n_clamped  = bus.n_stages;
    if (bus.n_stages == '0 || bus.n_stages > FullN) begin
      n_clamped = FullN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      stage_q    <= '0;
      timer_q    <= '0;
      peak_q     <= '0;
      clkp_q     <= '0;
      clkn_q     <= '1;
      mclk_q     <= 1'b0;
      inst_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BENNETT_ABORT_EN
      aborting_q <= 1'b0;
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef BENNETT_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (go) begin
            n_q     <= n_clamped;
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          mclk_q  <= 1'b1;
          timer_q <= '0;
          state_q <= StRaise;
        end
        StRaise: begin
          if (timer_done) begin
            timer_q         <= '0;
            clkp_q[stage_q] <= 1'b1;
            clkn_q[stage_q] <= 1'b0;
            stage_q         <= stage_q + 1'b1;
            if (stage_q + 1'b1 == n_q) begin
              inst_q  <= 1'b1;
              peak_q  <= '0;
              state_q <= StPeak;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`ifdef BENNETT_ABORT_EN
          // A due step still lands on the abort edge; the descent then starts from there.
          if (bus.abort) begin
            timer_q    <= '0;
            inst_q     <= 1'b0;
            aborting_q <= 1'b1;
            state_q    <= StLower;
          end
`endif
        end
        StPeak: begin
          if (peak_q == PeakLast) begin
            inst_q                  <= 1'b0;
            clkp_q[stage_q - 1'b1]  <= 1'b0;
            clkn_q[stage_q - 1'b1]  <= 1'b1;
            stage_q                 <= stage_q - 1'b1;
            timer_q                 <= '0;
            state_q                 <= StLower;
          end else begin
            peak_q <= peak_q + 1'b1;
          end
        end
        StLower: begin
          if (timer_done) begin
            timer_q <= '0;
            if (stage_q == '0) begin
              mclk_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StIdle;
`ifdef BENNETT_ABORT_EN
              aborted_q  <= aborting_q;
              aborting_q <= 1'b0;
`endif
            end else begin
              clkp_q[stage_q - 1'b1] <= 1'b0;
              clkn_q[stage_q - 1'b1] <= 1'b1;
              stage_q                <= stage_q - 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Mclk     = mclk_q;
  assign bus.busy     = mclk_q;
  assign bus.clkp     = clkp_q;
  assign bus.clkn     = clkn_q;
  assign bus.instFlag = inst_q;
  assign bus.done     = done_q;
  assign bus.stage    = stage_q;
`ifdef BENNETT_ABORT_EN
  assign bus.aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_bennett_clock_seq.sv
// Scoreboard bench for bennett_clock_seq: two instances (H=1/P=1 and H=2/P=3).
// Abort checks are compiled in when BENNETT_ABORT_EN is defined.
module tb_bennett_clock_seq;
  localparam int W = 12;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         mclk;
    logic         busy;
    logic [W-1:0] clkp;
    logic [W-1:0] clkn;
    logic         inst;
    logic         done;
    logic         aborted;
    logic [3:0]   stage;
  } snap_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  snap_t qa[$];
  snap_t qb[$];

  bennett_clock_seq_if #(.WIDTH(W)) bus_a ();
  bennett_clock_seq_if #(.WIDTH(W)) bus_b ();

  bennett_clock_seq #(.WIDTH(W), .HOLD(1), .PEAK_CYCLES(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  bennett_clock_seq #(.WIDTH(W), .HOLD(2), .PEAK_CYCLES(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t sample(input int w);
    snap_t s;
    s.cyc = cyc;
    if (w == 0) begin
      s.mclk = bus_a.Mclk; s.busy = bus_a.busy; s.clkp = bus_a.clkp; s.clkn = bus_a.clkn;
      s.inst = bus_a.instFlag; s.done = bus_a.done; s.stage = bus_a.stage;
`ifdef BENNETT_ABORT_EN
      s.aborted = bus_a.aborted;
`else
      s.aborted = 1'b0;
`endif
    end else begin
      s.mclk = bus_b.Mclk; s.busy = bus_b.busy; s.clkp = bus_b.clkp; s.clkn = bus_b.clkn;
      s.inst = bus_b.instFlag; s.done = bus_b.done; s.stage = bus_b.stage;
`ifdef BENNETT_ABORT_EN
      s.aborted = bus_b.aborted;
`else
      s.aborted = 1'b0;
`endif
    end
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("cyc=%0d mclk=%b busy=%b clkp=%h clkn=%h inst=%b done=%b aborted=%b stage=%0d",
                     s.cyc, s.mclk, s.busy, s.clkp, s.clkn, s.inst, s.done, s.aborted, s.stage);
  endfunction

  // Closed-form expected waveform for edges 1..min(tend,last_t) after acceptance edge e0.
  task automatic push_trace(input int w, input int n, input int h, input int p, input int e0,
                            input int last_t);
    int tend;
    snap_t s;
    tend = 1 + 2 * h * n + p;
    for (int t = 1; t <= tend && t <= last_t; t++) begin
      s = '0;
      s.cyc = e0 + t;
      for (int k = 0; k < n; k++) begin
        if (t >= 1 + h * (k + 1) && t < 1 + h * n + p + h * (n - 1 - k)) begin
          s.clkp[k] = 1'b1;
          s.stage   = s.stage + 4'd1;
        end
      end
      s.clkn = ~s.clkp;
      s.mclk = (t < tend);
      s.busy = s.mclk;
      s.done = (t == tend);
      s.inst = (t >= 1 + h * n) && (t < 1 + h * n + p);
      if (w == 0) qa.push_back(s);
      else qb.push_back(s);
    end
  endtask

  task automatic check_edge(input int w);
    snap_t got, exp;
    got = sample(w);
    if (got.busy || got.done) begin
      checks++;
      if ((w == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_output dut=%0d got %s, required no activity", w, fmt(got));
      end else begin
        exp = (w == 0) ? qa.pop_front() : qb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL trace dut=%0d got %s, required %s", w, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_edge(0);
    check_edge(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int w, input string name);
    snap_t got, exp;
    got      = sample(w);
    exp      = '0;
    exp.cyc  = cyc;
    exp.clkn = '1;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %s, required %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic start_dut(input int w, input int n_in, input int n_eff, input int h,
                           input int p, input int last_t, output int e0);
    e0 = cyc + 1;
    push_trace(w, n_eff, h, p, e0, last_t);
    if (w == 0) begin
      bus_a.n_stages = 4'(n_in); bus_a.start = 1'b1;
    end else begin
      bus_b.n_stages = 4'(n_in); bus_b.start = 1'b1;
    end
    tick();
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_idle(input int w, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (w == 0 ? (qa.size() == 0 && !bus_a.busy && !bus_a.done)
                 : (qb.size() == 0 && !bus_b.busy && !bus_b.done)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: got busy or pending trace after 400 cycles, required idle", name);
    end
  endtask

  initial begin
    int e0;
    bus_a.start = 1'b0; bus_a.auto_run = 1'b0; bus_a.n_stages = '0;
    bus_b.start = 1'b0; bus_b.auto_run = 1'b0; bus_b.n_stages = '0;
`ifdef BENNETT_ABORT_EN
    bus_a.abort = 1'b0;
    bus_b.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_reset(0, "reset_state_a");
    check_reset(1, "reset_state_b");
    tick();

    // Full 12-stage cycle, H=1 P=1.
    start_dut(0, 12, 12, 1, 1, 99, e0);
    wait_idle(0, "single_cycle");

    // Partial 4 stages, H=2 P=3.
    start_dut(1, 4, 4, 2, 3, 99, e0);
    wait_idle(1, "partial_stages");

    // n_stages=0 clamps to 12; start pulses and n_stages changes while busy are ignored.
    start_dut(0, 0, 12, 1, 1, 99, e0);
    repeat (5) tick();
    bus_a.start = 1'b1; bus_a.n_stages = 4'd3;
    tick();
    bus_a.start = 1'b0;
    repeat (10) tick();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    wait_idle(0, "clamp_zero");
    start_dut(0, 15, 12, 1, 1, 99, e0);
    bus_a.n_stages = 4'd1;
    wait_idle(0, "clamp_fifteen");

    // auto_run: back-to-back N=3 cycles, next acceptance on the edge after done.
    e0 = cyc + 1;
    push_trace(0, 3, 1, 1, e0, 99);
    push_trace(0, 3, 1, 1, e0 + 9, 99);
    push_trace(0, 3, 1, 1, e0 + 18, 99);
    bus_a.n_stages = 4'd3;
    bus_a.auto_run = 1'b1;
    for (int i = 0; i < 100 && cyc < e0 + 18; i++) tick();
    bus_a.auto_run = 1'b0;
    wait_idle(0, "auto_run");

    // Asynchronous reset in the middle of PEAK.
    start_dut(0, 12, 12, 1, 1, 13, e0);
    for (int i = 0; i < 100 && cyc < e0 + 13; i++) tick();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset(0, "reset_mid_peak");
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL mid_peak_trace got %0d pending edges, required 0", qa.size());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    check_reset(0, "after_reset_release");
    start_dut(0, 2, 2, 1, 1, 99, e0);
    wait_idle(0, "post_reset_cycle");

`ifdef BENNETT_ABORT_EN
    begin
      logic [W-1:0] ab_clkp [8];
      logic [3:0]   ab_stage[8];
      snap_t s;
      ab_clkp  = '{12'h000, 12'h001, 12'h003, 12'h007, 12'h003, 12'h001, 12'h000, 12'h000};
      ab_stage = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
      start_dut(0, 8, 8, 1, 1, 0, e0);
      for (int t = 1; t <= 8; t++) begin
        s         = '0;
        s.cyc     = e0 + t;
        s.clkp    = ab_clkp[t-1];
        s.clkn    = ~ab_clkp[t-1];
        s.stage   = ab_stage[t-1];
        s.mclk    = (t < 8);
        s.busy    = (t < 8);
        s.done    = (t == 8);
        s.aborted = (t == 8);
        qa.push_back(s);
      end
      for (int i = 0; i < 100 && cyc < e0 + 3; i++) tick();
      bus_a.abort = 1'b1;
      tick();
      bus_a.abort = 1'b0;
      wait_idle(0, "abort_in_raise");
    end
`endif

    repeat (3) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending edges, required 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
